// File: rtl/vga_layer_mixer.sv
// Two-stage priority compositor for N_CH layer pixel streams with per-frame sprite-overlap flags.
// Define VGA_MIXER_WINNER_EN to add the out_sel port reporting the winning layer index.
`timescale 1ns/1ps
module vga_layer_mixer #(
    parameter int N_CH = 10,
    parameter int DATA_W = 12,
    parameter logic [DATA_W-1:0] TRANSP = 12'h000,
    parameter logic [DATA_W-1:0] BG_COLOR = 12'h000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        layer_en,
    input  logic                   frame_start,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [N_CH-1:0]        coll_flags,
    output logic                   coll_irq
`ifdef VGA_MIXER_WINNER_EN
    ,
    output logic [$clog2(N_CH+1)-1:0] out_sel
`endif
);

    // True when at least two bits of the opaque vector are set.
    function automatic logic multi_opaque(input logic [N_CH-1:0] v);
        logic seen_one;
        logic seen_two;
        seen_one = 1'b0;
        seen_two = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (v[i]) begin
                seen_two = seen_two | seen_one;
                seen_one = 1'b1;
            end
        end
        return seen_two;
    endfunction

    logic [N_CH-1:0]        opq_s;
    logic                   s1_valid_r;
    logic [N_CH*DATA_W-1:0] s1_data_r;
    logic [N_CH-1:0]        s1_opq_r;
    logic [DATA_W-1:0]      win_data_s;
    logic [N_CH-1:0]        acc_r;
    logic [N_CH-1:0]        contrib_s;
    logic [N_CH-1:0]        next_flags_s;

    // Opaque mask of the incoming pixel slot.
    always_comb begin
        opq_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            opq_s[i] = layer_en[i] && (in_data[i*DATA_W +: DATA_W] != TRANSP);
        end
    end

    // Stage 1 register: raw pixel data, opaque mask and slot valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_opq_r   <= '0;
        end else begin
            s1_valid_r <= in_valid;
            s1_data_r  <= in_data;
            s1_opq_r   <= opq_s;
        end
    end

    // Priority pick of the stage-1 data; descending scan so the lowest opaque index is written last.
    always_comb begin
        win_data_s = BG_COLOR;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (s1_opq_r[i]) begin
                win_data_s = s1_data_r[i*DATA_W +: DATA_W];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // The S1 pixel is folded into the published flags when the frame closes on its cycle.
    always_comb begin
        if (s1_valid_r && multi_opaque(s1_opq_r)) begin
            contrib_s = s1_opq_r;
        end else begin
            contrib_s = '0;
        end
        next_flags_s = acc_r | contrib_s;
    end

    // Collision accumulator and frame-close publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= '0;
            coll_flags <= '0;
            coll_irq   <= 1'b0;
        end else if (frame_start) begin
            acc_r      <= '0;
            coll_flags <= next_flags_s;
            coll_irq   <= |next_flags_s;
        end else begin
            acc_r      <= next_flags_s;
            coll_irq   <= 1'b0;
        end
    end

    // Stage 2 register: composited pixel, held while no valid slot arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= BG_COLOR;
        end else begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_data <= win_data_s;
            end else begin
                out_data <= out_data;
            end
        end
    end

`ifdef VGA_MIXER_WINNER_EN
    localparam int SEL_W = $clog2(N_CH + 1);
    logic [SEL_W-1:0] win_sel_s;

    // Winning index, N_CH meaning background.
    always_comb begin
        win_sel_s = SEL_W'(N_CH);
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (s1_opq_r[i]) begin
                win_sel_s = SEL_W'(i);
            end else begin
                win_sel_s = win_sel_s;
            end
        end
    end

    // Winner index register aligned with out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sel <= SEL_W'(N_CH);
        end else if (s1_valid_r) begin
            out_sel <= win_sel_s;
        end else begin
            out_sel <= out_sel;
        end
    end
`endif

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Scoreboard bench for vga_layer_mixer (N_CH=4): directed vectors, collision flags, reset flush, random stream.
`timescale 1ns/1ps
module tb_vga_layer_mixer;
    localparam int N = 4;
    localparam int W = 12;
    localparam logic [11:0] BG = 12'h5A5;

    typedef struct packed {
        logic [11:0] data;
        logic [2:0]  sel;
        logic [31:0] cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   layer_en;
    logic           frame_start;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [N-1:0]   coll_flags;
    logic           coll_irq;
`ifdef VGA_MIXER_WINNER_EN
    logic [2:0]     out_sel;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 32'd0;
    exp_t        sbq[$];

    vga_layer_mixer #(.N_CH(N), .DATA_W(W), .TRANSP(12'h000), .BG_COLOR(BG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .layer_en(layer_en),
        .frame_start(frame_start), .out_valid(out_valid), .out_data(out_data),
        .coll_flags(coll_flags), .coll_irq(coll_irq)
`ifdef VGA_MIXER_WINNER_EN
        , .out_sel(out_sel)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    // Present one pixel for one cycle and queue its hand-computed result.
    task automatic send(input logic [N*W-1:0] d, input logic [N-1:0] en,
                        input logic [11:0] ed, input logic [2:0] es, input logic fs);
        exp_t e;
        in_valid    = 1'b1;
        in_data     = d;
        layer_en    = en;
        frame_start = fs;
        e.data = ed;
        e.sel  = es;
        e.cyc  = cyc + 32'd2;
        sbq.push_back(e);
        cycle();
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    // Reference winner for the random stream: first opaque enabled layer from index 0.
    function automatic exp_t model(input logic [N*W-1:0] d, input logic [N-1:0] en);
        exp_t e;
        e.data = BG;
        e.sel  = 3'd4;
        e.cyc  = 32'd0;
        for (int i = 0; i < N; i++) begin
            if (en[i] && d[i*W +: W] != 12'h000) begin
                e.data = d[i*W +: W];
                e.sel  = 3'(i);
                break;
            end
        end
        return e;
    endfunction

    // Monitor: pop and compare whenever the DUT presents a valid pixel.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual out_data %0h required no output", out_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_data", {20'd0, out_data}, {20'd0, e.data});
                chk("latency_cycle", cyc, e.cyc);
`ifdef VGA_MIXER_WINNER_EN
                chk("out_sel", {29'd0, out_sel}, {29'd0, e.sel});
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]   macc;
        logic [N*W-1:0] d;
        logic [N-1:0]   en;
        logic [N-1:0]   opq;
        int             nopq;
        int             ov;
        exp_t           e;

        rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0; in_data = '0; layer_en = 4'hF;
        repeat (3) cycle();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {20'd0, out_data}, {20'd0, BG});
        chk("rst_coll_flags", {28'd0, coll_flags}, 32'd0);
        chk("rst_coll_irq", {31'd0, coll_irq}, 32'd0);
`ifdef VGA_MIXER_WINNER_EN
        chk("rst_out_sel", {29'd0, out_sel}, 32'd4);
`endif
        rst = 1'b0;
        cycle();

        // Priority selection patterns.
        send({12'h000, 12'h0F0, 12'h000, 12'hF00}, 4'hF, 12'hF00, 3'd0, 1'b0);
        send({12'hABC, 12'h000, 12'h123, 12'h000}, 4'hF, 12'h123, 3'd1, 1'b0);
        send({12'h000, 12'h000, 12'h0F0, 12'hF00}, 4'b1110, 12'h0F0, 3'd1, 1'b0);
        idle(4);
        chk("hold_out_data", {20'd0, out_data}, 32'h0F0);
        send({12'h000, 12'h000, 12'h000, 12'h000}, 4'hF, BG, 3'd4, 1'b0);
        send({12'h000, 12'h00F, 12'h000, 12'h000}, 4'b1011, BG, 3'd4, 1'b0);
        idle(4);

        // Close the frame holding overlaps {0,2} and {1,3}.
        frame_start = 1'b1; cycle();
        chk("frame0_flags", {28'd0, coll_flags}, 32'hF);
        chk("frame0_irq", {31'd0, coll_irq}, 32'd1);
        frame_start = 1'b0; cycle();
        chk("frame0_irq_drop", {31'd0, coll_irq}, 32'd0);

        // Overlap still in S1 when frame_start is sampled.
        send({12'h00F, 12'h000, 12'h0F0, 12'h000}, 4'hF, 12'h0F0, 3'd1, 1'b0);
        frame_start = 1'b1; cycle();
        chk("s1_close_flags", {28'd0, coll_flags}, 32'hA);
        chk("s1_close_irq", {31'd0, coll_irq}, 32'd1);
        frame_start = 1'b0; cycle();
        chk("s1_close_irq_drop", {31'd0, coll_irq}, 32'd0);
        chk("s1_close_flags_hold", {28'd0, coll_flags}, 32'hA);
        idle(2);

        // Pixel with frame_start belongs to the new frame.
        send({12'h000, 12'h0F0, 12'h000, 12'hF00}, 4'hF, 12'hF00, 3'd0, 1'b1);
        chk("newframe_flags", {28'd0, coll_flags}, 32'd0);
        chk("newframe_irq", {31'd0, coll_irq}, 32'd0);
        idle(3);
        frame_start = 1'b1; cycle();
        chk("next_close_flags", {28'd0, coll_flags}, 32'h5);
        chk("next_close_irq", {31'd0, coll_irq}, 32'd1);
        cycle();
        chk("b2b_flags", {28'd0, coll_flags}, 32'd0);
        chk("b2b_irq", {31'd0, coll_irq}, 32'd0);
        frame_start = 1'b0;
        idle(2);

        // Continuous random stream of 640 pixels, layer_en changing every 64.
        macc = '0;
        en = 4'hF;
        for (int i = 0; i < 640; i++) begin
            if (i % 64 == 0) en = 4'($urandom_range(0, 15));
            for (int k = 0; k < N; k++) begin
                d[k*W +: W] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(1, 4095)) : 12'h000;
            end
            nopq = 0;
            for (int k = 0; k < N; k++) begin
                opq[k] = en[k] && (d[k*W +: W] != 12'h000);
                if (opq[k]) nopq++;
            end
            if (nopq >= 2) macc = macc | opq;
            e = model(d, en);
            send(d, en, e.data, e.sel, 1'b0);
        end
        idle(3);
        frame_start = 1'b1; cycle();
        chk("stream_flags", {28'd0, coll_flags}, {28'd0, macc});
        chk("stream_irq", {31'd0, coll_irq}, {31'd0, (macc != 4'd0)});
        frame_start = 1'b0;
        for (int t = 0; t < 10 && sbq.size() != 0; t++) cycle();
        chk("drain_queue", sbq.size(), 32'd0);

        // Overlapping pixel accumulates, then reset one cycle later flushes it.
        send({12'h000, 12'h0F0, 12'h000, 12'hF00}, 4'hF, 12'hF00, 3'd0, 1'b0);
        idle(3);
        in_valid = 1'b1;
        in_data  = {12'h111, 12'h222, 12'h333, 12'h444};
        cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_flags", {28'd0, coll_flags}, 32'd0);
        chk("rst_mid_out_data", {20'd0, out_data}, {20'd0, BG});
`ifdef VGA_MIXER_WINNER_EN
        chk("rst_mid_out_sel", {29'd0, out_sel}, 32'd4);
`endif
        rst = 1'b0;
        ov = 0;
        for (int t = 0; t < 5; t++) begin
            cycle();
            if (out_valid) ov++;
        end
        chk("rst_no_out_valid", ov, 32'd0);
        frame_start = 1'b1; cycle();
        chk("rst_acc_cleared", {28'd0, coll_flags}, 32'd0);
        chk("rst_acc_irq", {31'd0, coll_irq}, 32'd0);
        frame_start = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
